// File: rtl/amm_header_fetch_master_if.sv
// Avalon-MM bus between the header fetch master and the 1024x32 DRAM slave port
// (fixed read latency 1, no waitrequest).
interface amm_header_fetch_master_if #(
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  // The master owns every strobe and address; readdata is valid the cycle after a read strobe.
  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/amm_header_fetch_master.sv
// Burst-reads the work header from on-chip DRAM into the hashing core and
// performs single-word write-backs (nonce/status) between fetches.
module amm_header_fetch_master #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        word_count,
  output logic              hdr_valid,
  output logic [4:0]        hdr_index,
  output logic [31:0]       hdr_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_data,
  output logic              wb_ack,
  output logic              busy,
  output logic              done,
  amm_header_fetch_master_if.master avm
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  localparam logic [5:0]        MAX_CNT  = 6'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [5:0] cnt;
  logic [4:0] i;
  logic       zero_fetch;
  logic       pend;
  logic [4:0] pend_idx;
  logic [5:0] clamped;

  assign clamped = (word_count > MAX_CNT) ? MAX_CNT : word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      i                  <= '0;
      zero_fetch         <= 1'b0;
      pend               <= 1'b0;
      pend_idx           <= '0;
      hdr_valid          <= 1'b0;
      hdr_index          <= '0;
      hdr_data           <= '0;
      wb_ack             <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_byteenable <= 4'h0;
      avm.avm_writedata  <= '0;
    end else begin
      done   <= 1'b0;
      wb_ack <= 1'b0;
      // Read pipeline: flag/index trail the issued read by one cycle, data lands one more later.
      pend      <= (state == READ);
      pend_idx  <= i;
      hdr_valid <= pend;
      if (pend) begin
        hdr_data  <= avm.avm_readdata;
        hdr_index <= pend_idx;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= clamped;
            i    <= '0;
            busy <= 1'b1;
            if (clamped == 6'd0) begin
              zero_fetch <= 1'b1;
              state      <= DONE;
            end else begin
              zero_fetch         <= 1'b0;
              avm.avm_address    <= base_addr;
              avm.avm_chipselect <= 1'b1;
              avm.avm_write      <= 1'b0;
              avm.avm_byteenable <= 4'hF;
              state              <= READ;
            end
          end else if (wb_req && !wb_ack) begin
            // wb_ack high means the previous write's request is still being withdrawn.
            avm.avm_address    <= wb_addr;
            avm.avm_writedata  <= wb_data;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write      <= 1'b1;
            avm.avm_byteenable <= 4'hF;
            busy               <= 1'b1;
            state              <= WRITE;
          end
        end
        READ: begin
          if ({1'b0, i} == cnt - 6'd1) begin
            avm.avm_chipselect <= 1'b0;
            avm.avm_byteenable <= 4'h0;
            avm.avm_address    <= '0;
            state              <= DRAIN;
          end else begin
            i               <= i + 5'd1;
            avm.avm_address <= avm.avm_address + ADDR_ONE;
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        WRITE: begin
          avm.avm_chipselect <= 1'b0;
          avm.avm_write      <= 1'b0;
          avm.avm_byteenable <= 4'h0;
          avm.avm_address    <= '0;
          avm.avm_writedata  <= '0;
          wb_ack             <= 1'b1;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        DONE: begin
          // An empty fetch reports done one cycle later, from IDLE.
          done  <= zero_fetch;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amm_header_fetch_master.sv
// Directed bench for amm_header_fetch_master with a behavioural 1024x32 latency-1 memory.
module tb_amm_header_fetch_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [5:0]  word_count;
  logic        hdr_valid;
  logic [4:0]  hdr_index;
  logic [31:0] hdr_data;
  logic        wb_req;
  logic [9:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];

  amm_header_fetch_master_if #(.ADDR_W(10)) bus ();

  amm_header_fetch_master #(.ADDR_W(10), .MAX_WORDS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .hdr_valid  (hdr_valid),
    .hdr_index  (hdr_index),
    .hdr_data   (hdr_data),
    .wb_req     (wb_req),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ack     (wb_ack),
    .busy       (busy),
    .done       (done),
    .avm        (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.avm_chipselect) begin
      if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
      else               bus.avm_readdata <= mem[bus.avm_address];
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0) and check every output through the IDLE cycle n+3.
  task run_fetch(input logic [9:0] b, input logic [5:0] wc, input int n, input int poke);
    logic [9:0] a;
    logic       exp_cs, exp_hv;
    base_addr  = b;
    word_count = wc;
    start      = 1'b1;
    for (int c = 1; c <= n + 3; c++) begin
      tick;
      exp_cs = (c >= 1) && (c <= n);
      exp_hv = (c >= 3) && (c <= n + 2);
      total++;
      if (bus.avm_chipselect !== exp_cs) begin
        bad++;
        $display("FAIL fetch_cs base=%h cyc=%0d got=%b want=%b", b, c, bus.avm_chipselect, exp_cs);
      end
      if (exp_cs) begin
        a = b + 10'(c - 1);
        total++;
        if (bus.avm_address !== a || bus.avm_write !== 1'b0 || bus.avm_byteenable !== 4'hF) begin
          bad++;
          $display("FAIL fetch_rd base=%h cyc=%0d got addr=%h wr=%b be=%h want addr=%h wr=0 be=f",
                   b, c, bus.avm_address, bus.avm_write, bus.avm_byteenable, a);
        end
      end else begin
        total++;
        if (bus.avm_byteenable !== 4'h0) begin
          bad++;
          $display("FAIL fetch_be_idle base=%h cyc=%0d got=%h want=0", b, c, bus.avm_byteenable);
        end
      end
      total++;
      if (hdr_valid !== exp_hv) begin
        bad++;
        $display("FAIL fetch_hv base=%h cyc=%0d got=%b want=%b", b, c, hdr_valid, exp_hv);
      end
      if (exp_hv) begin
        a = b + 10'(c - 3);
        total++;
        if (hdr_index !== 5'(c - 3) || hdr_data !== exp_mem[a]) begin
          bad++;
          $display("FAIL fetch_hdr base=%h cyc=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   b, c, hdr_index, hdr_data, c - 3, exp_mem[a]);
        end
      end
      total++;
      if (busy !== (c <= n + 2) || done !== (c == n + 2)) begin
        bad++;
        $display("FAIL fetch_busy_done base=%h cyc=%0d got busy=%b done=%b want busy=%b done=%b",
                 b, c, busy, done, c <= n + 2, c == n + 2);
      end
      start = (c == poke);
    end
  endtask

  task test_reset;
    reset = 1'b1; start = 1'b0; wb_req = 1'b0;
    base_addr = '0; word_count = '0; wb_addr = '0; wb_data = '0;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++;
      if ({hdr_valid, hdr_index, hdr_data, wb_ack, busy, done, bus.avm_address,
           bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.avm_writedata} !== '0) begin
        bad++;
        $display("FAIL reset_outputs k=%0d got hv=%b cs=%b busy=%b addr=%h be=%h", k, hdr_valid,
                 bus.avm_chipselect, busy, bus.avm_address, bus.avm_byteenable);
      end
    end
    reset = 1'b0;
    tick;
  endtask

  task test_basic;
    run_fetch(10'h010, 6'd20, 20, 0);
  endtask

  task test_wrap;
    run_fetch(10'h3FE, 6'd4, 4, 0);
  endtask

  task test_clamp;
    run_fetch(10'h100, 6'd40, 32, 0);
  endtask

  task test_back_to_back;
    run_fetch(10'h040, 6'd3, 3, 0);
    run_fetch(10'h080, 6'd1, 1, 0);
  endtask

  task test_start_while_busy;
    run_fetch(10'h060, 6'd5, 5, 2);
  endtask

  task test_zero;
    base_addr = 10'h100; word_count = 6'd0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      start = 1'b0;
      total++;
      if (bus.avm_chipselect !== 1'b0 || hdr_valid !== 1'b0 || busy !== (c == 1) || done !== (c == 2)) begin
        bad++;
        $display("FAIL zero_count cyc=%0d got cs=%b hv=%b busy=%b done=%b want cs=0 hv=0 busy=%b done=%b",
                 c, bus.avm_chipselect, hdr_valid, busy, done, c == 1, c == 2);
      end
    end
  endtask

  task test_writeback;
    wb_req = 1'b1; wb_addr = 10'h3F0; wb_data = 32'hDEADBEEF;
    tick;
    total++;
    if (bus.avm_chipselect !== 1'b1 || bus.avm_write !== 1'b1 || bus.avm_byteenable !== 4'hF ||
        bus.avm_address !== 10'h3F0 || bus.avm_writedata !== 32'hDEADBEEF || wb_ack !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wb_write got cs=%b wr=%b be=%h addr=%h data=%h ack=%b busy=%b want 1 1 f 3f0 deadbeef 0 1",
               bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.avm_address,
               bus.avm_writedata, wb_ack, busy);
    end
    tick;
    total++;
    if (wb_ack !== 1'b1 || bus.avm_chipselect !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wb_ack got ack=%b cs=%b busy=%b want ack=1 cs=0 busy=0", wb_ack, bus.avm_chipselect, busy);
    end
    wb_req = 1'b0;
    tick;
    total++;
    if (wb_ack !== 1'b0 || bus.avm_chipselect !== 1'b0) begin
      bad++;
      $display("FAIL wb_ack_pulse got ack=%b cs=%b want ack=0 cs=0", wb_ack, bus.avm_chipselect);
    end
    exp_mem[10'h3F0] = 32'hDEADBEEF;
    run_fetch(10'h3F0, 6'd2, 2, 0);
  endtask

  task test_collision;
    wb_req = 1'b1; wb_addr = 10'h050; wb_data = 32'h12345678;
    run_fetch(10'h020, 6'd3, 3, 0);
    tick;
    total++;
    if (bus.avm_chipselect !== 1'b1 || bus.avm_write !== 1'b1 || bus.avm_address !== 10'h050 ||
        bus.avm_writedata !== 32'h12345678) begin
      bad++;
      $display("FAIL collision_write got cs=%b wr=%b addr=%h data=%h want 1 1 050 12345678",
               bus.avm_chipselect, bus.avm_write, bus.avm_address, bus.avm_writedata);
    end
    tick;
    total++;
    if (wb_ack !== 1'b1) begin
      bad++;
      $display("FAIL collision_ack got=%b want=1", wb_ack);
    end
    wb_req = 1'b0;
    exp_mem[10'h050] = 32'h12345678;
    run_fetch(10'h04F, 6'd3, 3, 0);
  endtask

  task test_reset_mid;
    run_fetch_prefix();
    reset = 1'b1;
    tick;
    total++;
    if ({hdr_valid, hdr_index, hdr_data, wb_ack, busy, done, bus.avm_address,
         bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.avm_writedata} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got hv=%b idx=%0d data=%h cs=%b busy=%b addr=%h be=%h",
               hdr_valid, hdr_index, hdr_data, bus.avm_chipselect, busy, bus.avm_address, bus.avm_byteenable);
    end
    reset = 1'b0;
    for (int c = 7; c <= 26; c++) begin
      tick;
      total++;
      if (bus.avm_chipselect !== 1'b0 || hdr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet cyc=%0d got cs=%b hv=%b done=%b busy=%b want all 0",
                 c, bus.avm_chipselect, hdr_valid, done, busy);
      end
    end
    run_fetch(10'h030, 6'd5, 5, 0);
  endtask

  // Cycles 0..5 of a 20-word fetch; returns in cycle 5 so reset can be raised there.
  task run_fetch_prefix;
    base_addr = 10'h010; word_count = 6'd20; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      start = 1'b0;
    end
    total++;
    if (bus.avm_chipselect !== 1'b1 || bus.avm_address !== 10'h014) begin
      bad++;
      $display("FAIL reset_mid_pre got cs=%b addr=%h want cs=1 addr=014", bus.avm_chipselect, bus.avm_address);
    end
  endtask

  task test_wb_reset;
    wb_req = 1'b1; wb_addr = 10'h200; wb_data = 32'h0BADF00D;
    tick;
    reset = 1'b1;
    tick;
    total++;
    if (wb_ack !== 1'b0 || bus.avm_chipselect !== 1'b0) begin
      bad++;
      $display("FAIL wb_reset_ack got ack=%b cs=%b want 0 0", wb_ack, bus.avm_chipselect);
    end
    reset  = 1'b0;
    wb_req = 1'b0;
    tick;
    total++;
    if (wb_ack !== 1'b0 || bus.avm_chipselect !== 1'b0) begin
      bad++;
      $display("FAIL wb_reset_after got ack=%b cs=%b want 0 0", wb_ack, bus.avm_chipselect);
    end
    exp_mem[10'h200] = 32'h0BADF00D;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem[k]     = 32'hA5000000 + 32'(k);
      exp_mem[k] = 32'hA5000000 + 32'(k);
    end
    test_reset;
    test_basic;
    test_wrap;
    test_zero;
    test_clamp;
    test_back_to_back;
    test_writeback;
    test_collision;
    test_start_while_busy;
    test_reset_mid;
    test_wb_reset;
    run_fetch(10'h1FF, 6'd3, 3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
